// File: rtl/gty_seq_pkg.sv
// Shared types and helpers for the GTY quad bring-up sequencer.
// State encoding doubles as the debug value exported on the state port.
package gty_seq_pkg;

    typedef enum logic [2:0] {
        ST_STARTUP   = 3'd0,
        ST_QPLL_RST  = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_TX_WAIT   = 3'd3,
        ST_RX_WAIT   = 3'd4,
        ST_RUN       = 3'd5
    } seqstate_t;

    localparam int RETRY_WIDTH = 8;

    typedef struct packed {
        logic qpll_reset;
        logic tx_reset;
        logic rx_reset;
        logic tx_userrdy;
        logic rx_userrdy;
        logic quad_ready;
    } seq_out_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Moore output decode; unknown encodings fall back to the fully-reset pattern
    function automatic seq_out_t decode_outputs(input seqstate_t s);
        seq_out_t o;
        case (s)
            ST_STARTUP,
            ST_QPLL_RST:  o = 6'b111000;
            ST_WAIT_LOCK: o = 6'b011000;
            ST_TX_WAIT:   o = 6'b001100;
            ST_RX_WAIT:   o = 6'b000110;
            ST_RUN:       o = 6'b000111;
            default:      o = 6'b111000;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/gty_quad_bringup_seq_sync_bit.sv
// Two-flop synchronizer for status bits arriving from the transceiver/PLL
// domains; each bit gets its own independent flop pair.
module sync_bit #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic meta_reg;
            logic sync_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= d[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign q[gi] = sync_reg;
        end
    endgenerate

endmodule

// File: rtl/gty_quad_bringup_seq.sv
// Bring-up sequencer for one GTY quad: QPLL reset, lock wait, TX then RX
// reset release, with timeouts, lock-loss recovery and a saturating retry count.
module gty_quad_bringup_seq
    import gty_seq_pkg::*;
#(
    parameter int NUM_LANES       = 3,
    parameter int STARTUP_CYCLES  = 16384,
    parameter int QPLL_RST_CYCLES = 64,
    parameter int LOCK_TIMEOUT    = 1000000,
    parameter int DONE_TIMEOUT    = 262144
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   restart,
    input  logic                   qpll_lock,
    input  logic [NUM_LANES-1:0]   tx_reset_done,
    input  logic [NUM_LANES-1:0]   rx_reset_done,
    output logic                   qpll_reset,
    output logic                   tx_reset,
    output logic                   rx_reset,
    output logic                   tx_userrdy,
    output logic                   rx_userrdy,
    output logic                   quad_ready,
    output logic [2:0]             state,
    output logic [RETRY_WIDTH-1:0] retry_count
);

    localparam int MAX_CYCLES = max_int(max_int(STARTUP_CYCLES, QPLL_RST_CYCLES),
                                        max_int(LOCK_TIMEOUT, DONE_TIMEOUT));
    localparam int CNT_W = $clog2(MAX_CYCLES + 1);

    logic                 lock_s;
    logic [NUM_LANES-1:0] tx_done_s;
    logic [NUM_LANES-1:0] rx_done_s;
    logic                 tx_all;
    logic                 rx_all;

    sync_bit #(.WIDTH(1)) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (qpll_lock),
        .q     (lock_s)
    );

    sync_bit #(.WIDTH(NUM_LANES)) u_tx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (tx_reset_done),
        .q     (tx_done_s)
    );

    sync_bit #(.WIDTH(NUM_LANES)) u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx_reset_done),
        .q     (rx_done_s)
    );

    assign tx_all = &tx_done_s;
    assign rx_all = &rx_done_s;

    seqstate_t              state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [RETRY_WIDTH-1:0] retry_reg, retry_next;
    seq_out_t               out_reg;
    logic                   take;
    logic                   fail;
    logic                   expired;

    // Fixed-length states count N-1 down to 0; wait states allow the full timeout before giving up
    function automatic logic [CNT_W-1:0] reload_value(input seqstate_t s);
        case (s)
            ST_STARTUP:   return CNT_W'(STARTUP_CYCLES - 1);
            ST_QPLL_RST:  return CNT_W'(QPLL_RST_CYCLES - 1);
            ST_WAIT_LOCK: return CNT_W'(LOCK_TIMEOUT);
            ST_TX_WAIT,
            ST_RX_WAIT:   return CNT_W'(DONE_TIMEOUT);
            default:      return '0;
        endcase
    endfunction

    always_comb begin
        state_next = state_reg;
        take       = 1'b0;
        fail       = 1'b0;
        expired    = (cnt_reg == '0);

        case (state_reg)
            ST_STARTUP: begin
                if (expired) begin
                    state_next = ST_QPLL_RST;
                    take       = 1'b1;
                end
            end
            ST_QPLL_RST: begin
                if (expired) begin
                    state_next = ST_WAIT_LOCK;
                    take       = 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_next = ST_TX_WAIT;
                    take       = 1'b1;
                end else if (expired) begin
                    fail = 1'b1;
                end
            end
            ST_TX_WAIT: begin
                if (!lock_s || (!tx_all && expired)) begin
                    fail = 1'b1;
                end else if (tx_all) begin
                    state_next = ST_RX_WAIT;
                    take       = 1'b1;
                end
            end
            ST_RX_WAIT: begin
                if (!lock_s || (!rx_all && expired)) begin
                    fail = 1'b1;
                end else if (rx_all) begin
                    state_next = ST_RUN;
                    take       = 1'b1;
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    fail = 1'b1;
                end
            end
            default: begin
                state_next = ST_STARTUP;
                take       = 1'b1;
            end
        endcase

        if (fail) begin
            state_next = ST_QPLL_RST;
            take       = 1'b1;
        end

        // An operator restart is not a failure, so it suppresses the retry bump
        if (restart && (state_reg != ST_STARTUP)) begin
            state_next = ST_QPLL_RST;
            take       = 1'b1;
            fail       = 1'b0;
        end

        retry_next = retry_reg;
        if (fail && (retry_reg != '1)) begin
            retry_next = retry_reg + RETRY_WIDTH'(1);
        end

        if (take) begin
            cnt_next = reload_value(state_next);
        end else if (expired) begin
            cnt_next = cnt_reg;
        end else begin
            cnt_next = cnt_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_STARTUP;
            cnt_reg   <= reload_value(ST_STARTUP);
            retry_reg <= '0;
            out_reg   <= decode_outputs(ST_STARTUP);
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            retry_reg <= retry_next;
            out_reg   <= decode_outputs(state_next);
        end
    end

    assign qpll_reset  = out_reg.qpll_reset;
    assign tx_reset    = out_reg.tx_reset;
    assign rx_reset    = out_reg.rx_reset;
    assign tx_userrdy  = out_reg.tx_userrdy;
    assign rx_userrdy  = out_reg.rx_userrdy;
    assign quad_ready  = out_reg.quad_ready;
    assign state       = state_reg;
    assign retry_count = retry_reg;

endmodule

// File: tb/tb_gty_quad_bringup_seq.sv
// Bench for the quad bring-up sequencer: directed scenarios plus a randomized
// phase, every cycle compared against a dwell-time/queue reference model.
module tb_gty_quad_bringup_seq;

    localparam int P_LANES   = 3;
    localparam int P_STARTUP = 16;
    localparam int P_QPLL    = 4;
    localparam int P_LOCK_TO = 100;
    localparam int P_DONE_TO = 50;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               restart = 1'b0;
    logic               qpll_lock = 1'b0;
    logic [P_LANES-1:0] tx_reset_done = '0;
    logic [P_LANES-1:0] rx_reset_done = '0;
    logic               qpll_reset, tx_reset, rx_reset;
    logic               tx_userrdy, rx_userrdy, quad_ready;
    logic [2:0]         state;
    logic [7:0]         retry_count;

    always #5 clk = ~clk;

    gty_quad_bringup_seq #(
        .NUM_LANES       (P_LANES),
        .STARTUP_CYCLES  (P_STARTUP),
        .QPLL_RST_CYCLES (P_QPLL),
        .LOCK_TIMEOUT    (P_LOCK_TO),
        .DONE_TIMEOUT    (P_DONE_TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .restart       (restart),
        .qpll_lock     (qpll_lock),
        .tx_reset_done (tx_reset_done),
        .rx_reset_done (rx_reset_done),
        .qpll_reset    (qpll_reset),
        .tx_reset      (tx_reset),
        .rx_reset      (rx_reset),
        .tx_userrdy    (tx_userrdy),
        .rx_userrdy    (rx_userrdy),
        .quad_ready    (quad_ready),
        .state         (state),
        .retry_count   (retry_count)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Output table: {qpll_reset, tx_reset, rx_reset, tx_userrdy, rx_userrdy, quad_ready}
    function automatic logic [5:0] exp_outputs(input int s);
        case (s)
            0, 1:    return 6'b111000;
            2:       return 6'b011000;
            3:       return 6'b001100;
            4:       return 6'b000110;
            5:       return 6'b000111;
            default: return 6'b111000;
        endcase
    endfunction

    // Reference model: state number, cycles spent in the current state,
    // and a queue delaying the raw status by two samples.
    int         m_state = 0;
    int         m_spent = 0;
    int         m_retry = 0;
    logic [2:0] m_hist[$];

    task automatic model_step();
        logic [2:0] seen;
        bit lk, txa, rxa, fail, reenter;
        int nxt;
        if (!rst_n) begin
            m_state = 0;
            m_spent = 0;
            m_retry = 0;
            m_hist  = '{3'b000, 3'b000};
        end else begin
            seen = m_hist.pop_front();
            m_hist.push_back({qpll_lock, &tx_reset_done, &rx_reset_done});
            lk  = seen[2];
            txa = seen[1];
            rxa = seen[0];
            m_spent++;
            nxt     = m_state;
            fail    = 0;
            reenter = 0;
            if (restart && m_state != 0) begin
                nxt     = 1;
                reenter = 1;
            end else begin
                case (m_state)
                    0: if (m_spent == P_STARTUP) nxt = 1;
                    1: if (m_spent == P_QPLL) nxt = 2;
                    2: if (lk) nxt = 3;
                       else if (m_spent == P_LOCK_TO + 1) fail = 1;
                    3: if (!lk) fail = 1;
                       else if (txa) nxt = 4;
                       else if (m_spent == P_DONE_TO + 1) fail = 1;
                    4: if (!lk) fail = 1;
                       else if (rxa) nxt = 5;
                       else if (m_spent == P_DONE_TO + 1) fail = 1;
                    5: if (!lk) fail = 1;
                    default: nxt = 0;
                endcase
            end
            if (fail) begin
                nxt = 1;
                if (m_retry < 255) m_retry++;
            end
            if (nxt != m_state || reenter) m_spent = 0;
            m_state = nxt;
        end
    endtask

    // Lane stimulus: done flags drop while the model holds reset, rise after a delay
    int tx_cnt[P_LANES], rx_cnt[P_LANES], tx_delay[P_LANES], rx_delay[P_LANES];
    bit tx_stuck[P_LANES], rx_stuck[P_LANES];
    bit lanes_manual = 0;
    bit rand_delays = 0;

    task automatic lanes_update();
        logic [5:0] o;
        o = exp_outputs(m_state);
        for (int i = 0; i < P_LANES; i++) begin
            if (o[4]) begin
                tx_cnt[i] = 0;
                tx_reset_done[i] = 1'b0;
                if (rand_delays) tx_delay[i] = $urandom_range(0, 56);
            end else begin
                tx_cnt[i]++;
                tx_reset_done[i] = !tx_stuck[i] && (tx_cnt[i] >= tx_delay[i]);
            end
            if (o[3]) begin
                rx_cnt[i] = 0;
                rx_reset_done[i] = 1'b0;
                if (rand_delays) rx_delay[i] = $urandom_range(0, 56);
            end else begin
                rx_cnt[i]++;
                rx_reset_done[i] = !rx_stuck[i] && (rx_cnt[i] >= rx_delay[i]);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("cycle", {state, qpll_reset, tx_reset, rx_reset, tx_userrdy, rx_userrdy, quad_ready, retry_count},
              {m_state[2:0], exp_outputs(m_state), m_retry[7:0]});
        if (!lanes_manual) lanes_update();
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        restart = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic set_lanes(input int d, input bit stuck);
        for (int i = 0; i < P_LANES; i++) begin
            tx_delay[i] = d;
            rx_delay[i] = d;
            tx_stuck[i] = stuck;
            rx_stuck[i] = stuck;
        end
    endtask

    task automatic wait_state(input int s, input int limit, input string tag);
        for (int n = 0; n < limit && state != s[2:0]; n++) tick();
        check(tag, state, s);
    endtask

    initial begin
        int fall_cyc, ready_cyc, n, low_left, run_entries;
        logic [31:0] seq;
        logic prev_q;
        logic [2:0] prev_s;
        bit ever_ready, saw_tx;
        int entries[$];

        // Nominal bring-up, with a restart pulse inside STARTUP that must be ignored
        set_lanes(10, 0);
        qpll_lock = 1'b0;
        do_reset();
        check("rst_state", state, 0);
        check("rst_resets", {qpll_reset, tx_reset, rx_reset}, 3'b111);
        check("rst_ready", {tx_userrdy, rx_userrdy, quad_ready}, 3'b000);
        check("rst_retry", retry_count, 0);
        fall_cyc = -1;
        ready_cyc = -1;
        seq = 0;
        prev_q = qpll_reset;
        prev_s = state;
        for (int k = 0; k < 300; k++) begin
            restart = (cyc == 5);
            if (cyc == 39) qpll_lock = 1'b1;
            tick();
            if (cyc == 6) check("startup_restart_ignored", state, 0);
            if (prev_q && !qpll_reset && fall_cyc < 0) fall_cyc = cyc;
            if (state != prev_s) seq = (seq << 4) | 32'(state);
            prev_q = qpll_reset;
            prev_s = state;
            if (state == 3'd5) begin
                ready_cyc = cyc;
                break;
            end
        end
        restart = 1'b0;
        check("qpll_fall_cycle", fall_cyc, P_STARTUP + P_QPLL);
        check("state_sequence", seq, 32'h12345);
        check("nominal_ready", quad_ready, 1);
        check("nominal_retry", retry_count, 0);
        $display("nominal: qpll_reset fell at cycle %0d, RUN at cycle %0d", fall_cyc, ready_cyc);

        // One-cycle lock drop in RUN
        for (int k = 0; k < 5; k++) tick();
        qpll_lock = 1'b0;
        tick();
        qpll_lock = 1'b1;
        n = 1;
        while (quad_ready && n < 10) begin
            tick();
            n++;
        end
        check("lockloss_latency", n, 3);
        check("lockloss_resets", {qpll_reset, tx_reset, rx_reset}, 3'b111);
        check("lockloss_retry", retry_count, 1);
        wait_state(5, 300, "lockloss_recover");
        check("lockloss_ready", quad_ready, 1);
        $display("lock drop: quad_ready fell after %0d cycles, retry_count=%0d", n, retry_count);

        // rst_n pulse in RUN
        rst_n = 1'b0;
        tick();
        check("rstpulse_state", state, 0);
        check("rstpulse_resets", {qpll_reset, tx_reset, rx_reset}, 3'b111);
        check("rstpulse_retry", retry_count, 0);
        rst_n = 1'b1;
        cyc = 0;
        $display("rst_n pulse: state=%0d retry_count=%0d", state, retry_count);

        // Lock never arrives
        qpll_lock = 1'b0;
        do_reset();
        ever_ready = 0;
        prev_s = state;
        entries.delete();
        while (cyc < 345) begin
            tick();
            if (state == 3'd1 && prev_s != 3'd1) entries.push_back(cyc);
            if (quad_ready) ever_ready = 1;
            prev_s = state;
        end
        check("nolock_retry", retry_count, 3);
        check("nolock_period", (entries.size() >= 4) ? entries[3] - entries[2] : -1, P_LOCK_TO + 1 + P_QPLL);
        check("nolock_never_ready", ever_ready, 0);
        $display("no lock: %0d QPLL_RST entries, retry_count=%0d", entries.size(), retry_count);

        // Lane 2 TX reset-done stuck low
        set_lanes(5, 0);
        tx_stuck[2] = 1;
        qpll_lock = 1'b1;
        do_reset();
        saw_tx = 0;
        for (int k = 0; k < 300 && retry_count == 0; k++) begin
            tick();
            if (state == 3'd3) saw_tx = 1;
        end
        check("stuck_saw_tx_wait", saw_tx, 1);
        check("stuck_state", state, 1);
        check("stuck_retry", retry_count, 1);
        $display("tx stuck: timed out to state=%0d retry_count=%0d at cycle %0d", state, retry_count, cyc);
        tx_stuck[2] = 0;

        // Restart coincident with all-rx-done in RX_WAIT
        for (int i = 0; i < P_LANES; i++) rx_stuck[i] = 1;
        do_reset();
        wait_state(4, 300, "reach_rx_wait");
        lanes_manual = 1;
        rx_reset_done = '1;
        tick();
        tick();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("restart_state", state, 1);
        check("restart_retry", retry_count, 0);
        $display("restart in RX_WAIT: state=%0d retry_count=%0d", state, retry_count);
        lanes_manual = 0;
        set_lanes(5, 0);

        // Saturation: every attempt times out in TX_WAIT
        set_lanes(5, 1);
        do_reset();
        for (int k = 0; k < 300 * (P_QPLL + 1 + P_DONE_TO + 1) + 100; k++) tick();
        check("retry_saturated", retry_count, 255);
        $display("saturation: retry_count=%0d after %0d cycles", retry_count, cyc);
        set_lanes(5, 0);

        // Randomized lock drops, restarts and lane delays
        rand_delays = 1;
        qpll_lock = 1'b1;
        do_reset();
        low_left = 0;
        run_entries = 0;
        prev_s = state;
        for (int k = 0; k < 5000; k++) begin
            if (low_left > 0) begin
                qpll_lock = 1'b0;
                low_left--;
            end else begin
                qpll_lock = 1'b1;
                if ($urandom_range(0, 249) == 0) low_left = $urandom_range(1, 130);
            end
            restart = ($urandom_range(0, 399) == 0);
            tick();
            if (state == 3'd5 && prev_s != 3'd5) run_entries++;
            prev_s = state;
        end
        restart = 1'b0;
        $display("random: %0d cycles, %0d RUN entries, retry_count=%0d", 5000, run_entries, retry_count);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
